// File: rtl/boot_flash_fetch_pkg.sv
// ----------------------------------------------------------------------------
// boot_pkg : shared types and constants for the boot flash fetch engine
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package boot_pkg;

   localparam logic [31:0] BOOTLOADER_START   = 32'h1000_0000;
   localparam int          BOOT_WORD_W        = 32;
   localparam int          FLASH_WAIT_DEFAULT = 2;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DRAIN   = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/boot_flash_fetch_if.sv
// ----------------------------------------------------------------------------
// boot_flash_fetch_if : control, flash and stream signals of the fetch engine
// Revision : 1.0  (checksum member present with BOOT_FETCH_CHECKSUM_EN)
// ----------------------------------------------------------------------------
`default_nettype none

interface boot_flash_fetch_if;
   import boot_pkg::*;

   logic                   start;
   logic [31:0]            start_addr;
   logic [8:0]             word_count;
   logic                   abort;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [31:0]            flash_addr;
   logic                   flash_read_en;
   logic [BOOT_WORD_W-1:0] flash_data;
   logic                   out_valid;
   logic [BOOT_WORD_W-1:0] out_data;
   logic [7:0]             out_index;
   logic                   out_ready;
`ifdef BOOT_FETCH_CHECKSUM_EN
   logic [31:0]            checksum;
`endif

   modport master (
      input  start, start_addr, word_count, abort, flash_data, out_ready,
      output busy, done, err, flash_addr, flash_read_en, out_valid, out_data, out_index
`ifdef BOOT_FETCH_CHECKSUM_EN
      , output checksum
`endif
   );

   modport slave (
      output start, start_addr, word_count, abort, flash_data, out_ready,
      input  busy, done, err, flash_addr, flash_read_en, out_valid, out_data, out_index
`ifdef BOOT_FETCH_CHECKSUM_EN
      , input checksum
`endif
   );

endinterface

`default_nettype wire

// File: rtl/boot_fetch_fifo.sv
// ----------------------------------------------------------------------------
// boot_fetch_fifo : synchronous first-word-fall-through FIFO with flush
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module boot_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       push,
   input  wire logic [WIDTH-1:0]           wdata,
   input  wire logic                       pop,
   input  wire logic                       flush,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(DEPTH):0]          count,
   output logic [WIDTH-1:0]                rdata
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             wr_en;
   logic             rd_en;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   // Head is forced to zero when empty so the stream port never shows stale data
   assign rdata = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (rd_en) rd_q <= rd_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/boot_flash_fetch.sv
// ----------------------------------------------------------------------------
// boot_flash_fetch : fixed-latency flash burst reader streaming through a FIFO
// Revision : 1.0  (optional checksum: BOOT_FETCH_CHECKSUM_EN)
// ----------------------------------------------------------------------------
`default_nettype none

module boot_flash_fetch
   import boot_pkg::*;
#(
   parameter int WAIT_CYCLES = FLASH_WAIT_DEFAULT,
   parameter int FIFO_DEPTH  = 4,
   parameter int MAX_WORDS   = 256
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   boot_flash_fetch_if.master bus
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [8:0]  MAX_W     = 9'(MAX_WORDS);
   localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES > 1) ? (WAIT_CYCLES - 2) : 0);

   fetch_state_e state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [8:0]   count_q, count_d;
   logic [8:0]   issued_q, issued_d;
   logic [3:0]   wait_q, wait_d;
   logic         err_q, err_d;
   logic [7:0]   idx_q, idx_d;

   logic                   fifo_push;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CW-1:0]          fifo_count;
   logic [BOOT_WORD_W-1:0] fifo_rdata;
   logic                   abort_eff;
   logic                   handshake;
   logic                   issue_fire;
   logic                   start_ok;
   logic                   bad_count;

   // Abort wins over everything that would otherwise happen in the same cycle
   assign abort_eff  = bus.abort && (state_q != S_IDLE);
   assign handshake  = !fifo_empty && bus.out_ready && !abort_eff;
   assign issue_fire = (state_q == S_ISSUE) && !fifo_full;
   assign bad_count  = (bus.word_count == 9'd0) || (bus.word_count > MAX_W);

   boot_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BOOT_WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (bus.flash_data),
      .pop   (handshake),
      .flush (abort_eff),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .rdata (fifo_rdata)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      issued_d  = issued_q;
      wait_d    = wait_q;
      err_d     = err_q;
      idx_d     = handshake ? idx_q + 8'd1 : idx_q;
      fifo_push = 1'b0;
      start_ok  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bad_count) begin
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end else begin
                  start_ok = 1'b1;
                  addr_d   = bus.start_addr & ~32'h3;
                  count_d  = bus.word_count;
                  issued_d = 9'd0;
                  idx_d    = 8'd0;
                  err_d    = 1'b0;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (issue_fire) begin
               wait_d  = 4'd0;
               state_d = (WAIT_CYCLES == 1) ? S_CAPTURE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_CAPTURE;
            else                     wait_d  = wait_q + 4'd1;
         end
         S_CAPTURE: begin
            fifo_push = 1'b1;
            addr_d    = addr_q + 32'd4;
            issued_d  = issued_q + 9'd1;
            state_d   = (issued_d == count_q) ? S_DRAIN : S_ISSUE;
         end
         S_DRAIN: begin
            if (handshake && (fifo_count == CW'(1))) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort_eff) begin
         state_d   = S_IDLE;
         fifo_push = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         count_q  <= '0;
         issued_q <= '0;
         wait_q   <= '0;
         err_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         issued_q <= issued_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
      end
   end

   assign bus.busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                              (state_q == S_CAPTURE) || (state_q == S_DRAIN);
   assign bus.done          = (state_q == S_DONE);
   assign bus.err           = err_q;
   assign bus.flash_addr    = addr_q;
   assign bus.flash_read_en = issue_fire;
   assign bus.out_valid     = !fifo_empty;
   assign bus.out_data      = fifo_rdata;
   assign bus.out_index     = idx_q;

`ifdef BOOT_FETCH_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         csum_q <= '0;
      else if (start_ok)  csum_q <= '0;
      else if (handshake) csum_q <= csum_q + fifo_rdata;
   end

   assign bus.checksum = csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_boot_flash_fetch.sv
// ----------------------------------------------------------------------------
// tb_boot_flash_fetch : table-driven and randomized bench with a flash model
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_boot_flash_fetch;
   import boot_pkg::*;

   localparam int          W     = FLASH_WAIT_DEFAULT;
   localparam logic [31:0] XOR_K = 32'hB007_0001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   boot_flash_fetch_if bus();

   boot_flash_fetch #(
      .WAIT_CYCLES (W),
      .FIFO_DEPTH  (4),
      .MAX_WORDS   (256)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          strobes = 0;
   int          dones = 0;
   logic [31:0] csum_m = '0;
   logic [31:0] exp_data_q[$];
   logic [7:0]  exp_idx_q[$];

   // Flash: data for a strobed address appears W cycles after the strobe
   logic [32:0] pipe_q [W];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < W; k++) pipe_q[k] <= '0;
      end else begin
         pipe_q[0] <= {bus.flash_read_en, bus.flash_addr};
         for (int k = 1; k < W; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end
   assign bus.flash_data = pipe_q[W-1][32] ? (pipe_q[W-1][31:0] ^ XOR_K) : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=expired required=event", name);
   endtask

   // Scoreboard: every handshake must match the next word the burst rules predict
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.flash_read_en) strobes++;
         if (bus.done) dones++;
         if (bus.out_valid && bus.out_ready && !bus.abort) begin
            if (exp_data_q.size() == 0) begin
               chk("unexpected_word", bus.out_data, 32'h0);
               errors += (bus.out_data === 32'h0) ? 1 : 0;
            end else begin
               chk("out_data", bus.out_data, exp_data_q.pop_front());
               chk("out_index", 32'(bus.out_index), 32'(exp_idx_q.pop_front()));
               csum_m = csum_m + bus.out_data;
            end
         end
      end
   end

   task automatic expect_burst(input logic [31:0] addr, input int wc);
      logic [31:0] base;
      base = addr & ~32'h3;
      for (int i = 0; i < wc; i++) begin
         exp_data_q.push_back((base + 32'(i * 4)) ^ XOR_K);
         exp_idx_q.push_back(8'(i));
      end
      csum_m = '0;
   endtask

   task automatic pulse_start(input logic [31:0] addr, input logic [8:0] wc);
      bus.start      = 1'b1;
      bus.start_addr = addr;
      bus.word_count = wc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int s0, input int d0, input int wc, input bit rnd);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 4000 && !got; c++) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (bus.done) got = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!got) fail({tag, "_timeout"});
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'h0);
      chk({tag, "_err_clear"}, 32'(bus.err), 32'h0);
      chk({tag, "_strobes"}, 32'(strobes - s0), 32'(wc));
      chk({tag, "_words_left"}, 32'(exp_data_q.size()), 32'h0);
`ifdef BOOT_FETCH_CHECKSUM_EN
      chk({tag, "_checksum"}, bus.checksum, csum_m);
`endif
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(bus.busy), 32'h0);
      chk({tag, "_done_once"}, 32'(dones - d0), 32'h1);
   endtask

   task automatic run_burst(input string tag, input logic [31:0] addr, input logic [8:0] wc,
                            input bit rnd, input bit exp_err);
      int s0, d0;
      @(posedge clk); #1;
      s0 = strobes;
      d0 = dones;
      if (!exp_err) expect_burst(addr, int'(wc));
      pulse_start(addr, wc);
      if (exp_err) begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk({tag, "_err"}, 32'(bus.err), 32'h1);
         chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
         chk({tag, "_strobes"}, 32'(strobes - s0), 32'h0);
         chk({tag, "_done"}, 32'(dones - d0), 32'h0);
      end else begin
         wait_done(tag, s0, d0, int'(wc), rnd);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
      chk({tag, "_done"}, 32'(bus.done), 32'h0);
      chk({tag, "_err"}, 32'(bus.err), 32'h0);
      chk({tag, "_flash_addr"}, bus.flash_addr, 32'h0);
      chk({tag, "_read_en"}, 32'(bus.flash_read_en), 32'h0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
      chk({tag, "_out_data"}, bus.out_data, 32'h0);
      chk({tag, "_out_index"}, 32'(bus.out_index), 32'h0);
`ifdef BOOT_FETCH_CHECKSUM_EN
      chk({tag, "_checksum"}, bus.checksum, 32'h0);
`endif
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [8:0]  wc;
      bit          rnd;
      bit          exp_err;
   } vec_t;

   vec_t vec [8];

   initial begin
      int s0, d0, n;

      vec[0] = '{32'h1000_0000, 9'd4,   1'b0, 1'b0};
      vec[1] = '{32'h1000_0000, 9'd0,   1'b0, 1'b1};
      vec[2] = '{32'h1000_0000, 9'd257, 1'b0, 1'b1};
      vec[3] = '{32'h1000_0100, 9'd1,   1'b0, 1'b0};
      vec[4] = '{32'h2000_0003, 9'd5,   1'b1, 1'b0};
      vec[5] = '{32'hFFFF_FFF0, 9'd6,   1'b1, 1'b0};
      vec[6] = '{32'h0000_0000, 9'd511, 1'b0, 1'b1};
      vec[7] = '{32'h1000_0000, 9'd256, 1'b1, 1'b0};

      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.word_count = '0;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b1;

      repeat (2) @(posedge clk); #1;
      check_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_burst($sformatf("vec%0d", i), vec[i].addr, vec[i].wc, vec[i].rnd, vec[i].exp_err);
`ifdef BOOT_FETCH_CHECKSUM_EN
         if (i == 0) chk("nominal_checksum", bus.checksum, 32'h801C_001C);
`endif
      end

      // Backpressure: FIFO fills after four reads and issuing must stall
      @(posedge clk); #1;
      s0 = strobes;
      d0 = dones;
      bus.out_ready = 1'b0;
      expect_burst(32'h1000_0000, 8);
      pulse_start(32'h1000_0000, 9'd8);
      repeat (40) @(posedge clk);
      #1;
      chk("bp_strobes_stalled", 32'(strobes - s0), 32'h4);
      chk("bp_read_en_low", 32'(bus.flash_read_en), 32'h0);
      chk("bp_valid_held", 32'(bus.out_valid), 32'h1);
      chk("bp_index_held", 32'(bus.out_index), 32'h0);
      wait_done("bp", s0, d0, 8, 1'b0);

      // Abort in WAIT after the second strobe of a six-word burst
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      s0 = strobes;
      d0 = dones;
      pulse_start(32'h1000_0000, 9'd6);
      n = 0;
      for (int c = 0; c < 200 && n < 2; c++) begin
         @(negedge clk);
         if (bus.flash_read_en) n++;
      end
      if (n < 2) fail("abort_strobe_wait");
      @(posedge clk); #1;
      chk("abort_pre_valid", 32'(bus.out_valid), 32'h1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
      chk("abort_busy", 32'(bus.busy), 32'h0);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_fifo_empty", 32'(bus.out_valid), 32'h0);
      chk("abort_no_done", 32'(dones - d0), 32'h0);
      chk("abort_strobes", 32'(strobes - s0), 32'h2);
      bus.out_ready = 1'b1;
      run_burst("wrap", 32'hFFFF_FFFC, 9'd2, 1'b0, 1'b0);

      // Reset while a strobe is high
      @(posedge clk); #1;
      expect_burst(32'h1000_0040, 8);
      pulse_start(32'h1000_0040, 9'd8);
      n = 0;
      for (int c = 0; c < 200 && n < 3; c++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (bus.flash_read_en) n++;
      end
      if (n < 3) fail("reset_strobe_wait");
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      exp_data_q.delete();
      exp_idx_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", 32'(bus.busy), 32'h0);
      chk("post_reset_valid", 32'(bus.out_valid), 32'h0);
      run_burst("post_reset", BOOTLOADER_START, 9'd3, 1'b1, 1'b0);

      for (int r = 0; r < 6; r++) begin
         run_burst($sformatf("rand%0d", r), $urandom, 9'($urandom_range(1, 24)), 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/boot_flash_fetch.md
Name: boot_flash_fetch

Overview:
Upstream fetch engine for the secure-boot verifier. On a start request it reads a burst of 32-bit words from external flash, which has a fixed access latency. It buffers the words in a small FIFO and streams them downstream over a valid/ready interface, so the bootloader verify stage can consume at its own pace. It reports busy, done and parameter-error status to the boot sequencer.

Parameters:
- WAIT_CYCLES, 2, flash latency: cycles from the flash_read_en cycle to the flash_data capture cycle (legal range 1..15).
- FIFO_DEPTH, 4, output buffer depth in words (power of 2, at least 2).
- MAX_WORDS, 256, largest legal burst length.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle burst request; ignored while busy=1
- start_addr  in  32  byte address of the first word; bits [1:0] are ignored (treated as 0)
- word_count  in  9  burst length in words
- abort  in  1  cancel the current burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the last word is handed off
- err  out  1  sticky parameter error; cleared by the next accepted start
- flash_addr  out  32  flash word address
- flash_read_en  out  1  one-cycle read strobe
- flash_data  in  32  flash read data
- out_valid  out  1  downstream data valid
- out_data  out  32  downstream word
- out_index  out  8  word index within the burst (0-based)
- out_ready  in  1  downstream accept
- checksum  out  32  present only with CHECKSUM_EN

Behaviour:
- Reset: all outputs are 0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DRAIN, DONE, ERROR.
- IDLE:
  - start with word_count==0 or word_count>MAX_WORDS -> ERROR.
  - Any other start -> latch start_addr and word_count; clear err, the issued count, the output index and checksum; busy=1; go to ISSUE.
- ISSUE:
  - Issue only when fifo_count < FIFO_DEPTH. Exactly one read is outstanding at any time, so a free slot is guaranteed at capture.
  - flash_read_en=1 for one cycle with flash_addr = current address -> WAIT.
  - flash_read_en is 0 in every other state.
- WAIT: count WAIT_CYCLES-1 cycles, then go to CAPTURE.
- CAPTURE:
  - Push flash_data into the FIFO. This cycle is exactly WAIT_CYCLES after the strobe cycle.
  - Address += 4, modulo 2^32 (wraps 0xFFFF_FFFC -> 0x0000_0000).
  - Issued count += 1. If issued == word_count -> DRAIN, else -> ISSUE.
- Throughput: one word per WAIT_CYCLES+1 cycles when not backpressured.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head (first-word fall-through).
  - Handshake occurs on out_valid && out_ready; it pops the FIFO and increments out_index (8-bit, wraps only after index 255).
  - out_data and out_index hold stable while out_valid && !out_ready.
- Simultaneous push and pop in one cycle are both honoured; fifo_count is unchanged.
- DRAIN: when the final word handshakes -> DONE.
- DONE: done=1 for one cycle; busy=0 -> IDLE.
- ERROR: err=1 (sticky), busy=0 -> IDLE.
- abort (any state other than IDLE), effective next cycle:
  - FSM -> IDLE; FIFO flushed; out_valid=0; busy=0; no done pulse.
  - Any in-flight flash datum is discarded.
  - abort takes priority over a same-cycle handshake or capture.
- start while busy: ignored, no side effects.
- Reset mid-burst: immediate return to reset values; flash_read_en drops asynchronously.

Optional Feature:
- Macro: BOOT_FETCH_CHECKSUM_EN.
- Defined:
  - checksum port exists; it is the 32-bit wrapping sum of every handed-off out_data.
  - Cleared on an accepted start; frozen from done until the next accepted start.
  - Holds its partial value after abort.
- Undefined: the checksum port and its adder are absent; all other behaviour is identical.

Decomposition:
- Package boot_pkg holds:
  - the FSM state enum;
  - BOOTLOADER_START = 32'h1000_0000;
  - BOOT_WORD_W = 32;
  - the FLASH_WAIT_DEFAULT constant.
- Sub-module boot_fetch_fifo: synchronous first-word-fall-through FIFO, parameterised by DEPTH.
  - Ports: push, pop, flush, full, empty, count.

Test Plan:
- Nominal burst:
  - Setup: WAIT_CYCLES=2; flash model returns addr^32'hB007_0001 with 2-cycle latency; out_ready=1.
  - Stimulus: start, start_addr=32'h1000_0000, word_count=4.
  - Required: out_data sequence A007_0001, A007_0005, A007_0009, A007_000D with out_index 0..3; done pulses once; busy is 0 the following cycle.
- Backpressure:
  - Stimulus: same burst with word_count=8, out_ready=0 for 40 cycles.
  - Required: exactly 4 flash strobes, then flash_read_en stays 0; after out_ready=1, all 8 words arrive in order with no loss or duplication.
- Parameter errors:
  - word_count=0 -> err=1, busy=0, zero flash strobes.
  - word_count=257 -> same response.
  - A following valid start clears err.
- Abort:
  - Stimulus: abort in the WAIT state after the 2nd strobe of a 6-word burst.
  - Required: out_valid=0 next cycle, FIFO empty, no done.
  - Then: a new 2-word burst from 32'hFFFF_FFFC outputs words for 32'hFFFF_FFFC and 32'h0000_0000 (address wrap).
- Reset mid-burst: rst_n low for 3 cycles -> every output reads 0 in the first reset cycle; after release the FSM is in IDLE.
- Checksum (BOOT_FETCH_CHECKSUM_EN defined): repeat the nominal burst -> checksum == 32'h801C_001C when done pulses.
